// File: rtl/custom_axi_ip_regs_if.sv
// custom_axi_ip_regs_if: AXI4-Lite bus between the SoC interconnect (master) and the register file (slave).
interface custom_axi_ip_regs_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/custom_axi_ip_regs.sv
// custom_axi_ip_regs: AXI4-Lite register file feeding the custom IP core (DATA_IN, START)
// and capturing its result/status (DATA_OUT, STATUS with sticky DONE and START_ERR).
module custom_axi_ip_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    custom_axi_ip_regs_if.slave  axi,
    output logic [31:0]          reg_data_o,
    output logic                 reg_start_o,
    input  logic [31:0]          hw_data_i,
    input  logic [1:0]           hw_status_i
);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_DONE = 2'd2;

    if (DATA_WIDTH != 32 || ADDR_WIDTH < 4) begin : g_param_check
        $error("custom_axi_ip_regs: DATA_WIDTH must be 32 and ADDR_WIDTH at least 4");
    end

    logic        init_q;
    logic        aw_full_q, aw_full_d, aw_oor_q, aw_oor_d;
    logic [1:0]  aw_idx_q, aw_idx_d;
    logic        w_full_q, w_full_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d, data_in_q, data_in_d, data_out_q, data_out_d;
    logic        done_q, done_d, err_q, err_d, start_q, start_d;
    logic [1:0]  status_prev_q;
    logic        wr_fire, done_edge, ar_oor, unused_addr_bits;
    logic [1:0]  ar_idx;
    logic [31:0] rd_word;

    // Readies stay low until the first clock after reset release.
    assign axi.s_axi_awready = init_q & ~aw_full_q;
    assign axi.s_axi_wready  = init_q & ~w_full_q;
    assign axi.s_axi_arready = init_q & ~rvalid_q;
    assign axi.s_axi_bvalid  = bvalid_q;
    assign axi.s_axi_bresp   = bresp_q;
    assign axi.s_axi_rvalid  = rvalid_q;
    assign axi.s_axi_rresp   = rresp_q;
    assign axi.s_axi_rdata   = rdata_q;
    assign reg_data_o        = data_in_q;
    assign reg_start_o       = start_q;

    assign wr_fire          = aw_full_q & w_full_q & ~bvalid_q;
    assign done_edge        = hw_status_i == ST_DONE && status_prev_q != ST_DONE;
    assign ar_idx           = axi.s_axi_araddr[3:2];
    assign ar_oor           = (axi.s_axi_araddr >> 4) != '0;
    assign unused_addr_bits = ^{axi.s_axi_araddr[1:0], axi.s_axi_awaddr[1:0]};
    assign rd_word          = ar_idx == 2'd1 ? data_in_q :
                              ar_idx == 2'd2 ? data_out_q :
                              ar_idx == 2'd3 ? {22'd0, err_q, done_q, 6'd0, hw_status_i} : 32'd0;

    always_comb begin
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        aw_oor_d   = aw_oor_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q & ~axi.s_axi_bready;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q & ~axi.s_axi_rready;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        data_in_d  = data_in_q;
        data_out_d = data_out_q;
        done_d     = done_q;
        err_d      = err_q;
        start_d    = 1'b0;
        if (axi.s_axi_awvalid && axi.s_axi_awready) begin
            aw_full_d = 1'b1;
            aw_idx_d  = axi.s_axi_awaddr[3:2];
            aw_oor_d  = (axi.s_axi_awaddr >> 4) != '0;
        end
        if (axi.s_axi_wvalid && axi.s_axi_wready) begin
            w_full_d = 1'b1;
            w_data_d = axi.s_axi_wdata;
            w_strb_d = axi.s_axi_wstrb;
        end
        if (wr_fire) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_oor_q ? SLVERR : OKAY;
            if (!aw_oor_q && aw_idx_q == 2'd0 && w_strb_q[0] && w_data_q[0]) begin
                start_d = hw_status_i == ST_IDLE;
                err_d   = err_q | (hw_status_i != ST_IDLE);
            end
            if (!aw_oor_q && aw_idx_q == 2'd1)
                for (int i = 0; i < 4; i++)
                    if (w_strb_q[i]) data_in_d[8*i +: 8] = w_data_q[8*i +: 8];
            if (!aw_oor_q && aw_idx_q == 2'd3 && w_strb_q[1]) begin
                done_d = done_q & ~w_data_q[8];
                err_d  = err_q & ~w_data_q[9];
            end
        end
        // A DONE edge overrides a same-cycle W1C so no completion is lost.
        if (done_edge) begin
            data_out_d = hw_data_i;
            done_d     = 1'b1;
        end
        if (axi.s_axi_arvalid && axi.s_axi_arready) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_oor ? SLVERR : OKAY;
            rdata_d  = ar_oor ? 32'd0 : rd_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q        <= 1'b0;
            aw_full_q     <= 1'b0;
            aw_idx_q      <= 2'd0;
            aw_oor_q      <= 1'b0;
            w_full_q      <= 1'b0;
            w_data_q      <= 32'd0;
            w_strb_q      <= 4'd0;
            bvalid_q      <= 1'b0;
            bresp_q       <= OKAY;
            rvalid_q      <= 1'b0;
            rdata_q       <= 32'd0;
            rresp_q       <= OKAY;
            data_in_q     <= 32'd0;
            data_out_q    <= 32'd0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            start_q       <= 1'b0;
            status_prev_q <= ST_IDLE;
        end else begin
            init_q        <= 1'b1;
            aw_full_q     <= aw_full_d;
            aw_idx_q      <= aw_idx_d;
            aw_oor_q      <= aw_oor_d;
            w_full_q      <= w_full_d;
            w_data_q      <= w_data_d;
            w_strb_q      <= w_strb_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            data_in_q     <= data_in_d;
            data_out_q    <= data_out_d;
            done_q        <= done_d;
            err_q         <= err_d;
            start_q       <= start_d;
            status_prev_q <= hw_status_i;
        end
    end
endmodule

// File: tb/tb_custom_axi_ip_regs.sv
// tb_custom_axi_ip_regs: directed and randomized AXI4-Lite traffic against a register-map
// model of custom_axi_ip_regs, plus start-pulse and response-count monitors.
module tb_custom_axi_ip_regs;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] reg_data_o;
    logic        reg_start_o;
    logic [31:0] hw_data_i = 32'd0;
    logic [1:0]  hw_status_i = 2'd0;

    int checks = 0, failures = 0;
    int start_cnt = 0, start_late = 0, b_rise = 0, exp_starts = 0;
    logic b_prev = 1'b0;
    logic [31:0] m_data_in, m_data_out;
    logic m_done, m_err;

    custom_axi_ip_regs_if axi ();

    custom_axi_ip_regs dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .axi         (axi),
        .reg_data_o  (reg_data_o),
        .reg_start_o (reg_start_o),
        .hw_data_i   (hw_data_i),
        .hw_status_i (hw_status_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Start pulses must coincide with the write response's first cycle.
    always @(negedge clk_i) begin
        if (reg_start_o) begin
            start_cnt++;
            if (!axi.s_axi_bvalid) start_late++;
        end
        if (axi.s_axi_bvalid && !b_prev) b_rise++;
        b_prev = axi.s_axi_bvalid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic sig(input int which);
        return which == 0 ? axi.s_axi_awready : which == 1 ? axi.s_axi_wready :
               which == 2 ? axi.s_axi_bvalid  : which == 3 ? axi.s_axi_arready : axi.s_axi_rvalid;
    endfunction

    task automatic wait_hi(input string tag, input int which);
        int n = 0;
        while (!sig(which) && n < 40) begin
            tick();
            n++;
        end
        if (n == 40) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic model_reset();
        m_data_in  = 32'd0;
        m_data_out = 32'd0;
        m_done     = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] idx = a[3:2];
        if (idx == 2'd0 && s[0] && d[0]) begin
            if (hw_status_i == 2'd0) exp_starts++;
            else m_err = 1'b1;
        end
        if (idx == 2'd1)
            for (int i = 0; i < 4; i++)
                if (s[i]) m_data_in[8*i +: 8] = d[8*i +: 8];
        if (idx == 2'd3 && s[1]) begin
            if (d[8]) m_done = 1'b0;
            if (d[9]) m_err = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [3:0] a);
        logic [31:0] st = 32'd0;
        st[1:0] = hw_status_i;
        st[8]   = m_done;
        st[9]   = m_err;
        case (a[3:2])
            2'd1:    return m_data_in;
            2'd2:    return m_data_out;
            2'd3:    return st;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_hw(input logic [1:0] st, input logic [31:0] d);
        hw_data_i = d;
        if (st == 2'd2 && hw_status_i != 2'd2) begin
            m_data_out = d;
            m_done     = 1'b1;
        end
        hw_status_i = st;
    endtask

    task automatic send_aw(input logic [3:0] a);
        axi.s_axi_awaddr  = a;
        axi.s_axi_awvalid = 1'b1;
        wait_hi("tmo_aw", 0);
        tick();
        axi.s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        axi.s_axi_wdata  = d;
        axi.s_axi_wstrb  = s;
        axi.s_axi_wvalid = 1'b1;
        wait_hi("tmo_w", 1);
        tick();
        axi.s_axi_wvalid = 1'b0;
    endtask

    task automatic get_b(input int hold);
        wait_hi("tmo_b", 2);
        repeat (hold) tick();
        if (hold > 0) chk("bvalid_hold", {31'd0, axi.s_axi_bvalid}, 32'd1);
        chk("bresp", {30'd0, axi.s_axi_bresp}, 32'd0);
        axi.s_axi_bready = 1'b1;
        tick();
        axi.s_axi_bready = 1'b0;
        chk("bvalid_clr", {31'd0, axi.s_axi_bvalid}, 32'd0);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd, input int hold);
        model_write(a, d, s);
        fork
            begin
                repeat (awd) tick();
                send_aw(a);
            end
            begin
                repeat (wd) tick();
                send_w(d, s);
            end
        join
        get_b(hold);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        axi.s_axi_araddr  = a;
        axi.s_axi_arvalid = 1'b1;
        wait_hi("tmo_ar", 3);
        tick();
        axi.s_axi_arvalid = 1'b0;
        wait_hi("tmo_r", 4);
        d = axi.s_axi_rdata;
        chk("rresp", {30'd0, axi.s_axi_rresp}, 32'd0);
        axi.s_axi_rready = 1'b1;
        tick();
        axi.s_axi_rready = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a);
        logic [31:0] d;
        axi_read(a, d);
        chk(tag, d, model_rd(a));
    endtask

    initial begin
        logic [31:0] d;
        int b0, s0;
        axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata = '0;  axi.s_axi_wstrb = '0; axi.s_axi_wvalid = 1'b0;
        axi.s_axi_bready = 1'b0;
        axi.s_axi_araddr = '0; axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_data", reg_data_o, 32'd0);
        chk("rst_start", {31'd0, reg_start_o}, 32'd0);
        chk("rst_ready", {29'd0, axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}, 32'd0);
        chk("rst_valid", {30'd0, axi.s_axi_bvalid, axi.s_axi_rvalid}, 32'd0);
        chk("rst_resp", {28'd0, axi.s_axi_bresp, axi.s_axi_rresp}, 32'd0);
        rst_ni = 1'b1;
        tick();
        axi_read(4'hC, d);
        chk("status_rst", d, 32'd0);

        axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(4'h4, 32'hA5A5_1234, 4'b0011, 0, 0, 0);
        chk("data_strb", reg_data_o, 32'hFFFF_1234);
        axi_read(4'h4, d);
        chk("data_rb", d, 32'hFFFF_1234);

        b0 = b_rise;
        model_write(4'h4, 32'h1357_9BDF, 4'hF);
        send_aw(4'h4);
        repeat (2) tick();
        send_w(32'h1357_9BDF, 4'hF);
        wait_hi("tmo_b", 2);
        chk("aw_ready_free", {31'd0, axi.s_axi_awready}, 32'd1);
        send_aw(4'h6);
        chk("aw_ready_held", {31'd0, axi.s_axi_awready}, 32'd0);
        repeat (3) tick();
        chk("b_held", {31'd0, axi.s_axi_bvalid}, 32'd1);
        chk("b_single", b_rise - b0, 32'd1);
        chk("data_aw_first", reg_data_o, 32'h1357_9BDF);
        axi.s_axi_bready = 1'b1;
        tick();
        axi.s_axi_bready = 1'b0;
        model_write(4'h6, 32'h2468_ACE0, 4'b1100);
        send_w(32'h2468_ACE0, 4'b1100);
        get_b(0);
        chk("data_pending", reg_data_o, 32'h2468_9BDF);
        chk("b_second", b_rise - b0, 32'd2);

        s0 = start_cnt;
        axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
        chk("start_pulse", start_cnt - s0, 32'd1);
        set_hw(2'd1, 32'd0);
        tick();
        axi_write(4'h0, 32'h1, 4'h1, 1, 0, 2);
        chk("start_busy", start_cnt - s0, 32'd1);
        axi_read(4'hC, d);
        chk("start_err", d, 32'h201);
        axi_write(4'hC, 32'h200, 4'hF, 0, 0, 0);
        axi_read(4'hC, d);
        chk("err_w1c", d, 32'h001);

        set_hw(2'd2, 32'h0000_0043);
        tick();
        axi_read(4'h8, d);
        chk("done_data", d, 32'h43);
        axi_read(4'hC, d);
        chk("done_status", d, 32'h102);

        set_hw(2'd1, 32'h99);
        tick();
        fork
            axi_write(4'hC, 32'h100, 4'hF, 0, 0, 0);
            begin
                tick();
                set_hw(2'd2, 32'h77);
            end
        join
        axi_read(4'hC, d);
        chk("w1c_vs_done", d, 32'h102);
        axi_read(4'h8, d);
        chk("done_data2", d, 32'h77);
        axi_write(4'hC, 32'h100, 4'hF, 0, 0, 0);
        axi_read(4'hC, d);
        chk("done_w1c", d, 32'h002);

        set_hw(2'd0, 32'd0);
        tick();
        axi.s_axi_araddr  = 4'h4;
        axi.s_axi_arvalid = 1'b1;
        wait_hi("tmo_ar", 3);
        tick();
        axi.s_axi_arvalid = 1'b0;
        wait_hi("tmo_r", 4);
        chk("rvalid_pend", {31'd0, axi.s_axi_rvalid}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst_rvalid", {31'd0, axi.s_axi_rvalid}, 32'd0);
        chk("rst_start_async", {31'd0, reg_start_o}, 32'd0);
        chk("rst_data_async", reg_data_o, 32'd0);
        model_reset();
        tick();
        rst_ni = 1'b1;
        tick();
        read_chk("post_rst_data", 4'h4);
        axi_write(4'h4, 32'hCAFE_F00D, 4'hF, 0, 2, 1);
        read_chk("post_rst_rw", 4'h4);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    logic [31:0] wd = $urandom;
                    if ($urandom_range(0, 1) == 1) wd[0] = 1'b1;
                    axi_write(4'($urandom_range(0, 15)), wd, 4'($urandom_range(0, 15)),
                              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                end
                2: read_chk("rand_rd", 4'($urandom_range(0, 15)));
                default: begin
                    set_hw(2'($urandom_range(0, 3)), $urandom);
                    tick();
                end
            endcase
        end
        for (int a = 0; a < 16; a += 4) read_chk("final_rd", 4'(a));
        chk("start_total", start_cnt, exp_starts);
        chk("start_timing", start_late, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
